// File: rtl/computer_pkg.sv
// Shared definitions for the computer: bus/RAM widths and loader state.
// Also holds the loader's state-to-control decoder.
package computer_pkg;

    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 8;
    localparam int CSUM_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        DRIVE_ADDR,
        DRIVE_DATA,
        CHECK,
        DONE
    } loader_state_t;

    typedef struct packed {
        logic in_ready;
        logic bus_drive;
        logic sel_addr;
        logic load_memory_address;
        logic ram_we;
        logic cpu_hold;
        logic done;
    } loader_ctl_t;

    function automatic loader_ctl_t decode_state(loader_state_t s);
        loader_ctl_t c;
        c = '0;
        unique case (1'b1)
            (s == WAIT_BYTE): begin
                c.in_ready = 1'b1;
            end
            (s == DRIVE_ADDR): begin
                c.bus_drive           = 1'b1;
                c.sel_addr            = 1'b1;
                c.load_memory_address = 1'b1;
            end
            (s == DRIVE_DATA): begin
                c.bus_drive = 1'b1;
                c.ram_we    = 1'b1;
            end
            (s == CHECK): begin
                c.in_ready = 1'b1;
            end
            (s == DONE): begin
                c.done = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        c.cpu_hold = (s != IDLE) && (s != DONE);
        return c;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and shared-bus output bundle of the program loader.
// master = loader side, slave = stream source / bus consumer side.
interface program_loader_if #(
    parameter int DW = computer_pkg::DATA_WIDTH
);

    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] bus_out;
    logic          bus_drive;
    logic          load_memory_address;
    logic          ram_we;
    logic          cpu_hold;
    logic          done;
    logic          checksum_err;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output bus_out,
        output bus_drive,
        output load_memory_address,
        output ram_we,
        output cpu_hold,
        output done,
        output checksum_err
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  bus_out,
        input  bus_drive,
        input  load_memory_address,
        input  ram_we,
        input  cpu_hold,
        input  done,
        input  checksum_err
    );

endinterface

// File: rtl/loader_checksum.sv
// Mod-256 byte accumulator with a sticky mismatch flag for the loader.
// Used only when PROGRAM_LOADER_CHECKSUM_EN is defined.
module loader_checksum
    import computer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  acc,
    input  logic [CSUM_WIDTH-1:0] acc_byte,
    input  logic                  cmp,
    input  logic [CSUM_WIDTH-1:0] cmp_byte,
    output logic                  err
);

    logic [CSUM_WIDTH-1:0] sum_q, sum_d;
    logic                  err_q, err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        sum_d = sum_q;
        err_d = err_q;
        if (clr) begin
            sum_d = '0;
            err_d = 1'b0;
        end else begin
            if (acc) begin
                sum_d = sum_q + acc_byte;
            end
            if (cmp && (cmp_byte != sum_q)) begin
                err_d = 1'b1;
            end
        end
    end

    assign err = err_q;

endmodule

// File: rtl/program_loader.sv
// Fills program RAM from a byte stream via the shared bus, holding the CPU.
// Define PROGRAM_LOADER_CHECKSUM_EN to add a trailing checksum byte check.
module program_loader #(
    parameter int ADDR_WIDTH = computer_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = computer_pkg::DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    program_loader_if.master lif
);

    import computer_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam loader_state_t END_STATE = CHECK;
`else
    localparam loader_state_t END_STATE = DONE;
`endif

    loader_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    loader_ctl_t           ctl;
    logic                  csum_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_BYTE;
                    addr_d  = '0;
                end
            end
            WAIT_BYTE: begin
                if (lif.in_valid) begin
                    data_d  = lif.in_data;
                    state_d = DRIVE_ADDR;
                end
            end
            DRIVE_ADDR: begin
                state_d = DRIVE_DATA;
            end
            DRIVE_DATA: begin
                // The last address always exits, so the counter never wraps.
                if (addr_q == LAST_ADDR) begin
                    state_d = END_STATE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = WAIT_BYTE;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (lif.in_valid) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ctl                     = decode_state(state_q);
        lif.in_ready            = ctl.in_ready;
        lif.bus_drive           = ctl.bus_drive;
        lif.load_memory_address = ctl.load_memory_address;
        lif.ram_we              = ctl.ram_we;
        lif.cpu_hold            = ctl.cpu_hold;
        lif.done                = ctl.done;
        lif.checksum_err        = csum_err;
        lif.bus_out             = '0;
        if (ctl.bus_drive) begin
            lif.bus_out = ctl.sel_addr ? DATA_WIDTH'(addr_q) : data_q;
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    loader_checksum u_csum (
        .clk      (clk),
        .reset    (reset),
        .clr      ((state_q == IDLE) && start),
        .acc      (state_q == DRIVE_DATA),
        .acc_byte (CSUM_WIDTH'(data_q)),
        .cmp      ((state_q == CHECK) && lif.in_valid),
        .cmp_byte (CSUM_WIDTH'(lif.in_data)),
        .err      (csum_err)
    );
`else
    assign csum_err = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: streams images, models MAR/RAM,
// checks timing, stalls, ignored start, mid-load reset and checksum.
module tb_program_loader;

    import computer_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 16;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic start;

    always #5 clk = ~clk;

    program_loader_if #(.DW(DW)) lif ();

    program_loader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .lif   (lif)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus-side model: MAR and RAM as the rest of the computer sees them.
    logic [DW-1:0] mem [N];
    logic [AW-1:0] mar = '0;
    int nwrites  = 0;
    int exp_addr = 0;
    int ndone    = 0;
    int done_cyc = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (!lif.bus_drive)
                check("bus_idle", 32'(lif.bus_out), 0);
            else
                check("rdy_busy", 32'(lif.in_ready), 0);
            if (lif.load_memory_address) begin
                check("mar_addr", 32'(lif.bus_out), exp_addr);
                mar = lif.bus_out[AW-1:0];
            end
            if (lif.ram_we) begin
                mem[mar] = lif.bus_out;
                nwrites++;
                exp_addr++;
            end
            if (lif.done) begin
                done_cyc = cyc;
                ndone++;
                check("hold_at_done", 32'(lif.cpu_hold), 0);
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int t;
        t  = 0;
        ok = 1'b1;
        @(negedge clk);
        while (!lif.in_ready) begin
            t++;
            if (t > 20) begin
                ok = 1'b0;
                check("rdy_timeout", 32'(lif.in_ready), 1);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy"}, 32'(lif.in_ready), 0);
        check({tag, "_drv"}, 32'(lif.bus_drive), 0);
        check({tag, "_bus"}, 32'(lif.bus_out), 0);
        check({tag, "_lma"}, 32'(lif.load_memory_address), 0);
        check({tag, "_we"}, 32'(lif.ram_we), 0);
        check({tag, "_hold"}, 32'(lif.cpu_hold), 0);
        check({tag, "_done"}, 32'(lif.done), 0);
        check({tag, "_cerr"}, 32'(lif.checksum_err), 0);
    endtask

    task automatic run_load(input logic [7:0] base, input logic [7:0] incr,
                            input int stall_at, input int restart_at,
                            input int reset_at, input logic [7:0] csum_off);
        bit ok;
        bit aborted;
        logic [7:0] b;
        logic [7:0] sum;
        int s_cyc;
        int t;
        aborted  = 1'b0;
        sum      = '0;
        exp_addr = 0;
        nwrites  = 0;
        ndone    = 0;
        foreach (mem[k]) mem[k] = '0;
        @(negedge clk);
        start = 1'b1;
        s_cyc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        check("hold_on", 32'(lif.cpu_hold), 1);
        check("cerr_clr", 32'(lif.checksum_err), 0);
        lif.in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            b = base + 8'(i) * incr;
            sum = sum + b;
            lif.in_data = b;
            wait_ready(ok);
            if (!ok) begin
                aborted = 1'b1;
                break;
            end
            if (i == stall_at) begin
                lif.in_valid = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    @(negedge clk);
                    check("stall_rdy", 32'(lif.in_ready), 1);
                end
                lif.in_valid = 1'b1;
            end
            if (i == restart_at) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            // Keep offering a different byte while the loader is busy.
            lif.in_data = ~b;
            if (i == reset_at) begin
                @(posedge clk);
                @(posedge clk);
                #1 lif.in_valid = 1'b0;
                reset = 1'b0;
                #1 check_all_zero("rst_mid");
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                check("rst_idle_hold", 32'(lif.cpu_hold), 0);
                check("rst_writes", nwrites, reset_at + 1);
                for (int k = 0; k <= reset_at; k++)
                    check("rst_image", 32'(mem[k]), 32'(base + 8'(k) * incr));
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            wait_ready(ok);
            lif.in_data = sum + csum_off;
            @(posedge clk);
            #1;
`endif
            lif.in_valid = 1'b0;
            t = 0;
            while (ndone == 0 && t < 12) begin
                @(negedge clk);
                t++;
            end
            check("done_seen", ndone, 1);
            check("done_cyc", done_cyc - s_cyc + 1,
                  50 + (stall_at >= 0 ? 5 : 0) + (CSUM_ON ? 1 : 0));
            @(negedge clk);
            check("done_pulse", 32'(lif.done), 0);
            check("hold_off", 32'(lif.cpu_hold), 0);
            check("writes", nwrites, N);
            check("ndone", ndone, 1);
            for (int k = 0; k < N; k++)
                check("image", 32'(mem[k]), 32'(base + 8'(k) * incr));
            check("cerr", 32'(lif.checksum_err),
                  32'(CSUM_ON && (csum_off != 0)));
        end
        lif.in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        lif.in_valid = 1'b0;
        lif.in_data  = '0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        lif.in_valid = 1'b1;
        @(negedge clk);
        check("idle_rdy", 32'(lif.in_ready), 0);
        check("idle_hold", 32'(lif.cpu_hold), 0);
        lif.in_valid = 1'b0;

        run_load(8'h10, 8'h01, -1, -1, -1, 8'h00);
        run_load(8'h20, 8'h01, 7, -1, -1, 8'h00);
        run_load(8'h30, 8'h01, -1, 4, -1, 8'h00);
        run_load(8'h40, 8'h01, -1, -1, 8, 8'h00);
        run_load(8'h50, 8'h01, -1, -1, -1, 8'h00);
        run_load(8'h01, 8'h00, -1, -1, -1, 8'h00);
        run_load(8'h01, 8'h00, -1, -1, -1, 8'h01);
        repeat (3) @(negedge clk);
        check("cerr_sticky", 32'(lif.checksum_err), 32'(CSUM_ON));
        run_load(8'h60, 8'h03, -1, -1, -1, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Bus-side writer that fills the computer's program RAM from an external byte stream before execution starts. The control FSM only reads RAM; this block is the write end of the same path. It holds the CPU, accepts bytes over a valid/ready handshake and drives the shared bus, `load_memory_address` and `ram_we` so that each byte lands at consecutive RAM addresses starting from 0. When the image is complete it releases the CPU.

## Interface
Parameters:
- `ADDR_WIDTH`, default 4: RAM address width. The image length is 2^ADDR_WIDTH bytes.
- `DATA_WIDTH`, default 8: width of the bus and of each byte.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock. All state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load. Sampled only in IDLE.
- `in_data`  in  DATA_WIDTH  incoming program byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `bus_out`  out  DATA_WIDTH  value the loader drives onto the shared bus.
- `bus_drive`  out  1  loader owns the bus. The top-level mux gives it highest priority.
- `load_memory_address`  out  1  MAR loads from the bus this cycle.
- `ram_we`  out  1  RAM writes the bus value this cycle.
- `cpu_hold`  out  1  control FSM must stay in reset/idle while this is high.
- `done`  out  1  one-cycle pulse when the load is complete.
- `checksum_err`  out  1  checksum mismatch flag. Exists only with the macro in Configuration.

## Operation
- Reset values: all outputs 0, state IDLE, address counter 0, captured byte 0.
- States and transitions:
  - IDLE → WAIT_BYTE on `start`. The address counter clears to 0.
  - WAIT_BYTE: `in_ready`=1. On `in_valid`, capture `in_data` and go to DRIVE_ADDR.
  - DRIVE_ADDR: `bus_drive`=1, `bus_out`={zero-extend, addr}, `load_memory_address`=1. Go to DRIVE_DATA.
  - DRIVE_DATA: `bus_drive`=1, `bus_out`=captured byte, `ram_we`=1.
    - If addr == 2^ADDR_WIDTH−1, go to DONE (or CHECK when the macro is defined).
    - Otherwise addr increments and the state returns to WAIT_BYTE.
  - DONE: `done`=1 for one cycle, then IDLE.
- `cpu_hold`=1 in every state except IDLE and DONE.
- `start` outside IDLE is ignored. A byte offered outside WAIT_BYTE is not consumed; `in_ready`=0 there.
- `bus_out`=0 whenever `bus_drive`=0.
- The address counter is ADDR_WIDTH bits and never wraps mid-load: the last address always exits to DONE/CHECK.
- Reset asserted mid-load: immediate return to IDLE with all outputs 0. RAM contents already written are left as-is.

## Timing
- `start` on edge n: WAIT_BYTE and `cpu_hold`=1 from cycle n+1.
- A byte is accepted on the edge where `in_valid`&&`in_ready`.
  - DRIVE_ADDR occupies the next cycle and DRIVE_DATA the one after.
  - `in_ready` reasserts 3 cycles after the accept.
- Minimum load time is 3·2^ADDR_WIDTH + 2 cycles from `start` to `done` (50 cycles for ADDR_WIDTH=4).
- `done` and the deassertion of `cpu_hold` occur in the same cycle.
- There are no combinational paths from inputs to outputs. All outputs are decoded from registered state.

## Configuration
- `PROGRAM_LOADER_CHECKSUM_EN` defined:
  - An 8-bit accumulator sums the data bytes mod 256.
  - After the last RAM write, state CHECK asserts `in_ready` and accepts one more byte (the checksum). Nothing is written to RAM.
  - `checksum_err` is set if that byte ≠ the accumulated sum; then DONE.
  - `checksum_err` is sticky until the next accepted `start` or reset.
- Not defined: no CHECK state and no accumulator; `checksum_err` is tied 0.

## Structure
- Shared package `computer_pkg`:
  - `loader_state_t` enum (IDLE, WAIT_BYTE, DRIVE_ADDR, DRIVE_DATA, CHECK, DONE).
  - `ADDR_WIDTH` and `DATA_WIDTH` default constants, also used by `ram` and the MAR.
- Sub-module `loader_checksum`: clear/accumulate/compare on 8 bits. Instantiated only under `PROGRAM_LOADER_CHECKSUM_EN`.

## Test plan
- Reset, then `start`; stream bytes 0x10..0x1F with `in_valid` held high → 16 writes to addresses 0..15 with matching data; `done` pulse at cycle 50; `cpu_hold` low afterward.
- Same stream with `in_valid` low for 5 cycles before byte 7 → loader stalls in WAIT_BYTE with `in_ready`=1 and the RAM image is identical; `done` at cycle 55.
- `start` pulsed again at address 4 mid-load → ignored: no address reset and no extra writes.
- Reset asserted low after the write to address 8 → all outputs 0 that cycle, state IDLE, addresses 0–8 hold their data; a new `start` begins writing again at address 0.
- Macro defined, bytes 0x01×16 then checksum 0x10 → `checksum_err`=0. Repeat with checksum 0x11 → `checksum_err`=1, held until the next `start`.
- `in_valid` high during DRIVE_ADDR/DRIVE_DATA → byte not consumed (`in_ready`=0) and `bus_out` unaffected.
